// File: rtl/isr_autopush_if.sv
// Handshake bundle between the PIO instruction-decode FSM (master) and the
// input shift register / RX FIFO push block (slave).
interface isr_autopush_if;
  logic        in_en;
  logic [31:0] in_data;
  logic [4:0]  in_count;
  logic        shiftdir;
  logic        autopush_en;
  logic [4:0]  push_thresh;
  logic        push_req;
  logic        push_iffull;
  logic        push_block;
  logic        clear;
  logic        rx_full;
  logic        rx_push_en;
  logic [31:0] rx_data;
  logic [31:0] isr;
  logic [5:0]  shift_counter;
  logic        stall;
  logic        overflow;

  modport master (
    output in_en, in_data, in_count, shiftdir, autopush_en, push_thresh,
           push_req, push_iffull, push_block, clear, rx_full,
    input  rx_push_en, rx_data, isr, shift_counter, stall, overflow
  );

  modport slave (
    input  in_en, in_data, in_count, shiftdir, autopush_en, push_thresh,
           push_req, push_iffull, push_block, clear, rx_full,
    output rx_push_en, rx_data, isr, shift_counter, stall, overflow
  );
endinterface

// File: rtl/isr_autopush.sv
// PIO input shift register with explicit/auto push into the RX FIFO and stall on full.
// Optional sticky RX-stall flag enabled by defining ISR_RXSTALL_FLAG_EN.
module isr_autopush #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ISR_RXSTALL_FLAG_EN
  input  logic             rxstall_clr_i,
  output logic             rxstall_flag_o,
`endif
  isr_autopush_if.slave    bus
);

  typedef enum logic [0:0] {
    IDLE       = 1'b0,
    STALL_PUSH = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] isr_q, isr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        push_q, push_d;
  logic [31:0] data_q, data_d;
  logic        stall_q, stall_d;
  logic        ovf_q, ovf_d;
  logic        flag_set_s;

  logic [5:0]  n_s;
  logic [5:0]  thresh_s;
  logic [31:0] mask_s;
  logic [31:0] src_s;
  logic [31:0] isr_next_s;
  logic [6:0]  cnt_sum_s;
  logic [5:0]  cnt_next_s;

  // Shift amount, threshold and shifted ISR candidate for an IN this cycle
  always_comb begin
    n_s      = (bus.in_count == 5'd0) ? 6'd32 : {1'b0, bus.in_count};
    thresh_s = (bus.push_thresh == 5'd0) ? 6'd32 : {1'b0, bus.push_thresh};
    // Shift amounts of 32 yield zero, so n=32 collapses to a plain load
    mask_s   = 32'hFFFF_FFFF >> (6'd32 - n_s);
    src_s    = bus.in_data & mask_s;
    if (bus.shiftdir) begin
      isr_next_s = (isr_q >> n_s) | (src_s << (6'd32 - n_s));
    end else begin
      isr_next_s = (isr_q << n_s) | src_s;
    end
    cnt_sum_s = {1'b0, cnt_q} + {1'b0, n_s};
    if (cnt_sum_s > 7'd32) begin
      cnt_next_s = 6'd32;
    end else begin
      cnt_next_s = cnt_sum_s[5:0];
    end
  end

  // Next-state and output decode; priority clear > stall resolution > IN > PUSH
  always_comb begin
    state_d    = state_q;
    isr_d      = isr_q;
    cnt_d      = cnt_q;
    push_d     = 1'b0;
    data_d     = data_q;
    ovf_d      = 1'b0;
    flag_set_s = 1'b0;
    if (bus.clear) begin
      isr_d   = 32'd0;
      cnt_d   = 6'd0;
      state_d = IDLE;
    end else begin
      case (state_q)
        STALL_PUSH: begin
          if (!bus.rx_full) begin
            push_d  = 1'b1;
            data_d  = isr_q;
            isr_d   = 32'd0;
            cnt_d   = 6'd0;
            state_d = IDLE;
          end else begin
            state_d = STALL_PUSH;
          end
        end
        IDLE: begin
          if (bus.in_en) begin
            isr_d = isr_next_s;
            cnt_d = cnt_next_s;
            if (bus.autopush_en && (cnt_next_s >= thresh_s)) begin
              if (!bus.rx_full) begin
                push_d = 1'b1;
                data_d = isr_next_s;
                isr_d  = 32'd0;
                cnt_d  = 6'd0;
              end else begin
                state_d    = STALL_PUSH;
                flag_set_s = 1'b1;
              end
            end else begin
              state_d = IDLE;
            end
          end else if (bus.push_req) begin
            if (bus.push_iffull && (cnt_q < thresh_s)) begin
              state_d = IDLE;
            end else if (!bus.rx_full) begin
              push_d = 1'b1;
              data_d = isr_q;
              isr_d  = 32'd0;
              cnt_d  = 6'd0;
            end else if (bus.push_block) begin
              state_d    = STALL_PUSH;
              flag_set_s = 1'b1;
            end else begin
              isr_d      = 32'd0;
              cnt_d      = 6'd0;
              ovf_d      = 1'b1;
              flag_set_s = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    stall_d = (state_d == STALL_PUSH);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      isr_q   <= 32'd0;
      cnt_q   <= 6'd0;
      push_q  <= 1'b0;
      data_q  <= 32'd0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      isr_q   <= isr_d;
      cnt_q   <= cnt_d;
      push_q  <= push_d;
      data_q  <= data_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef ISR_RXSTALL_FLAG_EN
  logic flag_q;

  // Sticky flag; a set in the same cycle as a clear takes precedence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
    end else if (flag_set_s) begin
      flag_q <= 1'b1;
    end else if (rxstall_clr_i) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_q;
    end
  end

  assign rxstall_flag_o = flag_q;
`endif

  assign bus.rx_push_en    = push_q;
  assign bus.rx_data       = data_q;
  assign bus.isr           = isr_q;
  assign bus.shift_counter = cnt_q;
  assign bus.stall         = stall_q;
  assign bus.overflow      = ovf_q;

endmodule
